// File: rtl/banked_lram.sv
// Banked byte RAM mapped into a CPU address window, with a bank-select register
// and a post-reset fill sequence that sweeps the whole physical array.
module banked_lram #(
  parameter logic [15:0] BASE           = 16'hC000,
  parameter int          SIZE           = 8192,
  parameter int          BANKBITS       = 3,
  parameter bit          FIXED_LOWER    = 1'b1,
  parameter bit          ZERO_REMAP     = 1'b1,
  parameter logic [15:0] REG_ADDR       = 16'hFF70,
  parameter logic [7:0]  FILL           = 8'hFF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] abs_addr,
  input  logic [7:0]  data_w,
  input  logic        write_enable,
  output logic [7:0]  data_r,
  output logic        hit,
  output logic        busy
);

  localparam int BANKS = 1 << BANKBITS;
  localparam int UNIT  = FIXED_LOWER ? SIZE / 2 : SIZE;
  localparam int DEPTH = BANKS * UNIT;
  localparam int SW    = $clog2(SIZE);
  localparam int UW    = $clog2(UNIT);
  localparam int AW    = BANKBITS + UW;

  // 17-bit bounds so a window ending exactly at 16'hFFFF is representable
  localparam logic [16:0] WIN_LO = {1'b0, BASE};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(SIZE);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [7:0]          mem [DEPTH];

  logic [0:0]          state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [BANKBITS-1:0] bank_q, bank_d;
  logic [7:0]          data_r_q, data_r_d;

  logic                win_hit, reg_hit;
  logic [SW-1:0]       rel;
  logic [BANKBITS-1:0] eff_bank, unit_sel;
  logic [AW-1:0]       phys;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [7:0]          mem_wdata;
  logic [7:0]          reg_rd;

  assign win_hit = ({1'b0, abs_addr} >= WIN_LO) && ({1'b0, abs_addr} < WIN_HI);
  assign reg_hit = (abs_addr == REG_ADDR);
  assign hit     = win_hit | reg_hit;
  assign busy    = (state_q == S_CLEAR);
  assign data_r  = data_r_q;

  assign rel      = abs_addr[SW-1:0] - BASE[SW-1:0];
  assign eff_bank = (ZERO_REMAP && (bank_q == '0)) ? BANKBITS'(1) : bank_q;

  // UNIT is a power of two, so unit*UNIT + offset is a plain concatenation
  always_comb begin
    unit_sel = eff_bank;
    if (FIXED_LOWER && !rel[SW-1]) unit_sel = '0;
    phys = {unit_sel, rel[UW-1:0]};
  end

  // Single write port shared by the fill sweep and the CPU; CPU writes are
  // simply lost while the sweep owns the port.
  always_comb begin
    mem_we    = win_hit & write_enable;
    mem_waddr = phys;
    mem_wdata = data_w;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(DEPTH - 1)) state_d = S_READY;
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (reg_hit && write_enable) bank_d = data_w[BANKBITS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_cnt_q <= '0;
      bank_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      bank_q    <= bank_d;
    end
  end

  always_comb begin
    reg_rd                 = 8'hFF;
    reg_rd[BANKBITS-1:0]   = bank_q;
  end

  // Read half a cycle after the posedge so same-cycle writes are visible
  always_comb begin
    data_r_d = data_r_q;
    if (win_hit)      data_r_d = busy ? 8'hFF : mem[phys];
    else if (reg_hit) data_r_d = reg_rd;
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) data_r_q <= 8'hFF;
    else          data_r_q <= data_r_d;
  end

endmodule

// File: tb/tb_banked_lram.sv
// Scoreboard bench for banked_lram: reads push expected bytes, the observed
// data_r after the read negedge is queued and compared at the end of each task.
module tb_banked_lram;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] abs_addr = '0;
  logic [7:0]  data_w = '0;
  logic        write_enable = 1'b0;
  logic [7:0]  data_r;
  logic        hit;
  logic        busy;

  int checks = 0;
  int passed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  string      nm_q[$];

  banked_lram dut (
    .clk(clk), .reset_n(reset_n), .abs_addr(abs_addr), .data_w(data_w),
    .write_enable(write_enable), .data_r(data_r), .hit(hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    abs_addr = a; data_w = d; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string name);
    @(negedge clk); #1;
    abs_addr = a; write_enable = 1'b0;
    exp_q.push_back(e); nm_q.push_back(name);
    @(negedge clk); #1;
    obs_q.push_back(data_r);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_r !== 8'hFF) $display("FAIL reset_data_r: got %h expected ff", data_r);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy);
    else passed++;
  endtask

  // Counts posedges until busy drops; issues a dropped window write and an
  // accepted bank write along the way.
  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40000) begin
      @(posedge clk); n++; #1;
      if (n == 1000) begin
        abs_addr = 16'hC100; data_w = 8'h42; write_enable = 1'b1;
      end else if (n == 2000) begin
        abs_addr = 16'hFF70; data_w = 8'h02; write_enable = 1'b1;
      end else begin
        write_enable = 1'b0;
      end
    end
    write_enable = 1'b0;
    checks++;
    if (n !== 32768) $display("FAIL %s: busy cycles %0d expected 32768", name, n);
    else passed++;
  endtask

  task automatic test_clear();
    @(negedge clk); #1 reset_n = 1'b1;
    count_clear("clear_len");
    rd(16'hD123, 8'hFF, "post_clear_D123");
    rd(16'hC100, 8'hFF, "busy_write_dropped");
    rd(16'hFF70, 8'hFA, "bank_write_while_busy");
    while (exp_q.size() > 0) begin
      logic [7:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s: got %h expected %h", s, o, e);
      else passed++;
    end
  endtask

  task automatic test_bank_switch();
    wr(16'hFF70, 8'h02); wr(16'hD010, 8'hA5);
    wr(16'hFF70, 8'h03); rd(16'hD010, 8'hFF, "bank3_D010");
    wr(16'hFF70, 8'h02); rd(16'hD010, 8'hA5, "bank2_D010");
    while (exp_q.size() > 0) begin
      logic [7:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s: got %h expected %h", s, o, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    wr(16'hD200, 8'h5A);
    exp_q.push_back(8'h5A); nm_q.push_back("write_then_read");
    @(negedge clk); #1 obs_q.push_back(data_r);
    wr(16'hD200, 8'h3C);
    exp_q.push_back(8'h3C); nm_q.push_back("rewrite_then_read");
    @(negedge clk); #1 obs_q.push_back(data_r);
    while (exp_q.size() > 0) begin
      logic [7:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s: got %h expected %h", s, o, e);
      else passed++;
    end
  endtask

  task automatic test_remap();
    wr(16'hFF70, 8'h00); wr(16'hD000, 8'h11);
    wr(16'hFF70, 8'h01); wr(16'hD000, 8'h22);
    wr(16'hFF70, 8'h00); rd(16'hD000, 8'h22, "remap_bank0");
    wr(16'hFF70, 8'h01); rd(16'hD000, 8'h22, "remap_bank1");
    rd(16'hC000, 8'hFF, "remap_lower_untouched");
    wr(16'hFF70, 8'h05); rd(16'hFF70, 8'hFD, "bank_reg_read");
    while (exp_q.size() > 0) begin
      logic [7:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s: got %h expected %h", s, o, e);
      else passed++;
    end
  endtask

  task automatic test_fixed_lower();
    wr(16'hFF70, 8'h03); wr(16'hC000, 8'h11);
    wr(16'hFF70, 8'h06); rd(16'hC000, 8'h11, "fixed_lower_C000");
    rd(16'hD000, 8'hFF, "bank6_D000_fill");
    while (exp_q.size() > 0) begin
      logic [7:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s: got %h expected %h", s, o, e);
      else passed++;
    end
  endtask

  task automatic test_boundary();
    logic [15:0] addrs [4];
    logic        hits  [4];
    addrs = '{16'hDFFF, 16'hE000, 16'hBFFF, 16'hFF70};
    hits  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1 abs_addr = addrs[i]; write_enable = 1'b0;
      #1;
      checks++;
      if (hit !== hits[i]) $display("FAIL hit_%h: got %b expected %b", addrs[i], hit, hits[i]);
      else passed++;
    end
    wr(16'hDFFF, 8'h77);
    exp_q.push_back(8'h77); nm_q.push_back("top_byte_DFFF");
    @(negedge clk); #1 obs_q.push_back(data_r);
    wr(16'hE000, 8'h99);
    exp_q.push_back(8'h77); nm_q.push_back("outside_holds_data_r");
    @(negedge clk); #1 obs_q.push_back(data_r);
    rd(16'hC000, 8'h11, "outside_write_ignored");
    rd(16'hDFFF, 8'h77, "reread_DFFF");
    while (exp_q.size() > 0) begin
      logic [7:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s: got %h expected %h", s, o, e);
      else passed++;
    end
  endtask

  task automatic test_mid_clear_reset();
    @(negedge clk); #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_reset_busy: got %b expected 1", busy);
    else passed++;
    reset_n = 1'b1;
    count_clear("restart_clear_len");
    rd(16'hC000, 8'hFF, "reclear_C000");
    rd(16'hFF70, 8'hFA, "bank_after_reclear");
    while (exp_q.size() > 0) begin
      logic [7:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s: got %h expected %h", s, o, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_bank_switch();
    test_back_to_back();
    test_remap();
    test_fixed_lower();
    test_boundary();
    test_mid_clear_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
